// File: rtl/praxos_mbox_ctrl_if.sv
// Wishbone pipelined bus bundle between the system crossbar (master) and
// the Praxos mailbox/control block (slave).
interface praxos_mbox_ctrl_if;
   logic [4:0]  wb_adr;
   logic [31:0] wb_dat_w;
   logic [3:0]  wb_sel;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [31:0] wb_dat_r;
   logic        wb_ack;
   logic        wb_err;
   logic        wb_stall;

   modport master (
      output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      input  wb_dat_r, wb_ack, wb_err, wb_stall
   );

   modport slave (
      input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
      output wb_dat_r, wb_ack, wb_err, wb_stall
   );
endinterface

// File: rtl/praxos_mbox_ctrl.sv
// Praxos control block: program-memory loader, core run control, masked IRQ
// bridge, shared GP registers and the two mailbox FIFOs (H2C and C2H).

// Single-clock 32-bit mailbox FIFO. A push when full and a pop when empty are
// refused without moving the pointers. The head reads 0 while empty. Flush
// overrides any same-cycle push or pop.
module praxos_mbox_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [31:0]              push_data,
   output logic [31:0]              head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign head      = empty ? 32'h0000_0000 : mem_r[rd_ptr_r];
   assign count     = count_r;

   // Pointer and occupancy tracking; flush empties the FIFO outright.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
      end
   end

   // Entry storage; contents are never observable while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end
endmodule

module praxos_mbox_ctrl #(
   parameter int NUM_GP     = 16,
   parameter int PM_AW      = 8,
   parameter int PM_DW      = 36,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   praxos_mbox_ctrl_if.slave  wb,
   input  logic [31:0]        irq_in,
   output logic               irq_out,
   output logic               praxos_rst_n,
   output logic [PM_AW-1:0]   praxos_pm_wr_addr,
   output logic               praxos_pm_wr,
   output logic [PM_DW-1:0]   praxos_pm_wr_data,
   input  logic [4:0]         praxos_port_addr,
   input  logic               praxos_port_rd,
   input  logic               praxos_port_wr,
   input  logic [31:0]        praxos_port_wr_data,
   output logic [31:0]        praxos_port_rd_data
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int HW = PM_DW - 32;

   localparam logic [4:0] A_IRQ_PEND = 5'd0;
   localparam logic [4:0] A_IRQ_IN   = 5'd1;
   localparam logic [4:0] A_PM_LO    = 5'd2;
   localparam logic [4:0] A_PM_HI    = 5'd3;
   localparam logic [4:0] A_PM_ADDR  = 5'd4;
   localparam logic [4:0] A_PM_GO    = 5'd5;
   localparam logic [4:0] A_CTRL     = 5'd6;
   localparam logic [4:0] A_IRQ_MASK = 5'd7;
   localparam logic [4:0] A_MBOX     = 5'd8;
   localparam logic [4:0] A_STATUS   = 5'd9;
   localparam logic [4:0] P_IRQ_SET  = 5'd0;
   localparam logic [4:0] P_IRQ_IN   = 5'd1;
   localparam logic [4:0] P_MBOX     = 5'd2;
   localparam logic [4:0] P_STATUS   = 5'd3;

   logic [31:0]      irq_pend_r, irq_mask_r, irq_in_r, pm_lo_r;
   logic [HW-1:0]    pm_hi_r;
   logic [PM_AW-1:0] pm_addr_r, pm_wr_addr_r;
   logic [PM_DW-1:0] pm_wr_data_r;
   logic             pm_wr_r, ctrl_run_r, irq_out_r;
   logic             h2c_ovf_r, c2h_udf_r, c2h_ovf_r, h2c_udf_r;
   logic [31:0]      gp_r [NUM_GP];
   logic             ack_r, err_r;
   logic [31:0]      dat_r_r;

   logic             wb_stb_s, wb_wr_s, wb_rd_s, wb_fault_s, flush_s;
   logic             wb_gp_hit_s, core_gp_hit_s;
   logic             h2c_push_s, h2c_pop_s, c2h_push_s, c2h_pop_s;
   logic             h2c_full_s, h2c_empty_s, c2h_full_s, c2h_empty_s;
   logic [31:0]      h2c_head_s, c2h_head_s;
   logic [CW-1:0]    h2c_cnt_s, c2h_cnt_s;
   logic [31:0]      wb_status_s, core_status_s, wb_rd_data_s;
   logic [31:0]      irq_clr_s, irq_set_s, irq_pend_nxt_s, irq_mask_nxt_s;
   logic             unused_sel_s;

   // Byte selects carry no meaning here; every access is a full word.
   assign unused_sel_s = ^wb.wb_sel;

   assign wb_stb_s      = wb.wb_cyc & wb.wb_stb;
   assign wb_wr_s       = wb_stb_s & wb.wb_we;
   assign wb_rd_s       = wb_stb_s & ~wb.wb_we;
   assign wb_gp_hit_s   = wb.wb_adr[4] && (32'(wb.wb_adr[3:0]) < 32'(NUM_GP));
   assign core_gp_hit_s = praxos_port_addr[4] && (32'(praxos_port_addr[3:0]) < 32'(NUM_GP));

   assign h2c_push_s = wb_wr_s && (wb.wb_adr == A_MBOX);
   assign c2h_pop_s  = wb_rd_s && (wb.wb_adr == A_MBOX);
   assign h2c_pop_s  = praxos_port_rd && (praxos_port_addr == P_MBOX);
   assign c2h_push_s = praxos_port_wr && (praxos_port_addr == P_MBOX);
   assign flush_s    = wb_wr_s && (wb.wb_adr == A_CTRL) && wb.wb_dat_w[1];
   assign wb_fault_s = (h2c_push_s & h2c_full_s) | (c2h_pop_s & c2h_empty_s);

   // Host-side and core-side status words differ only in which flags they show.
   assign wb_status_s   = {5'b0_0000, c2h_udf_r, h2c_ovf_r, 9'(c2h_cnt_s), 7'b000_0000, 9'(h2c_cnt_s)};
   assign core_status_s = {5'b0_0000, h2c_udf_r, c2h_ovf_r, 9'(c2h_cnt_s), 7'b000_0000, 9'(h2c_cnt_s)};

   praxos_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_h2c (
      .clk(clk), .rst_n(rst_n), .flush(flush_s), .push(h2c_push_s), .pop(h2c_pop_s),
      .push_data(wb.wb_dat_w), .head(h2c_head_s), .count(h2c_cnt_s),
      .full(h2c_full_s), .empty(h2c_empty_s)
   );

   praxos_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_c2h (
      .clk(clk), .rst_n(rst_n), .flush(flush_s), .push(c2h_push_s), .pop(c2h_pop_s),
      .push_data(praxos_port_wr_data), .head(c2h_head_s), .count(c2h_cnt_s),
      .full(c2h_full_s), .empty(c2h_empty_s)
   );

   // Host read mux, sampled from pre-edge state into the response register.
   always_comb begin
      wb_rd_data_s = 32'h0000_0000;
      case (wb.wb_adr)
         A_IRQ_PEND: wb_rd_data_s = irq_pend_r;
         A_IRQ_IN:   wb_rd_data_s = irq_in_r;
         A_PM_LO:    wb_rd_data_s = pm_lo_r;
         A_PM_HI:    wb_rd_data_s = 32'(pm_hi_r);
         A_PM_ADDR:  wb_rd_data_s = 32'(pm_addr_r);
         A_CTRL:     wb_rd_data_s = {31'h0000_0000, ctrl_run_r};
         A_IRQ_MASK: wb_rd_data_s = irq_mask_r;
         A_MBOX:     wb_rd_data_s = c2h_head_s;
         A_STATUS:   wb_rd_data_s = wb_status_s;
         default: begin
            if (wb_gp_hit_s) begin
               wb_rd_data_s = gp_r[wb.wb_adr[3:0]];
            end else begin
               wb_rd_data_s = 32'h0000_0000;
            end
         end
      endcase
   end

   // Core read mux; combinational so the core sees data in its access cycle.
   always_comb begin
      praxos_port_rd_data = 32'h0000_0000;
      case (praxos_port_addr)
         P_IRQ_IN: praxos_port_rd_data = irq_in_r;
         P_MBOX:   praxos_port_rd_data = h2c_head_s;
         P_STATUS: praxos_port_rd_data = core_status_s;
         default: begin
            if (core_gp_hit_s) begin
               praxos_port_rd_data = gp_r[praxos_port_addr[3:0]];
            end else begin
               praxos_port_rd_data = 32'h0000_0000;
            end
         end
      endcase
   end

   // Next pending/mask values: host clears first, a core set in the same cycle wins.
   always_comb begin
      irq_clr_s      = (wb_wr_s && (wb.wb_adr == A_IRQ_PEND)) ? wb.wb_dat_w : 32'h0000_0000;
      irq_set_s      = (praxos_port_wr && (praxos_port_addr == P_IRQ_SET)) ? praxos_port_wr_data : 32'h0000_0000;
      irq_pend_nxt_s = (irq_pend_r & ~irq_clr_s) | irq_set_s;
      irq_mask_nxt_s = (wb_wr_s && (wb.wb_adr == A_IRQ_MASK)) ? wb.wb_dat_w : irq_mask_r;
   end

   // One response per strobe, one cycle later; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_r   <= 1'b0;
         err_r   <= 1'b0;
         dat_r_r <= 32'h0000_0000;
      end else begin
         ack_r   <= wb_stb_s & ~wb_fault_s;
         err_r   <= wb_stb_s & wb_fault_s;
         dat_r_r <= wb_rd_s ? wb_rd_data_s : 32'h0000_0000;
      end
   end

   // Program-memory staging registers and the auto-incrementing write strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pm_lo_r      <= 32'h0000_0000;
         pm_hi_r      <= {HW{1'b0}};
         pm_addr_r    <= {PM_AW{1'b0}};
         pm_wr_r      <= 1'b0;
         pm_wr_addr_r <= {PM_AW{1'b0}};
         pm_wr_data_r <= {PM_DW{1'b0}};
      end else begin
         pm_wr_r <= 1'b0;
         if (wb_wr_s) begin
            case (wb.wb_adr)
               A_PM_LO:   pm_lo_r   <= wb.wb_dat_w;
               A_PM_HI:   pm_hi_r   <= wb.wb_dat_w[HW-1:0];
               A_PM_ADDR: pm_addr_r <= wb.wb_dat_w[PM_AW-1:0];
               A_PM_GO: begin
                  pm_wr_r      <= 1'b1;
                  pm_wr_addr_r <= pm_addr_r;
                  pm_wr_data_r <= {pm_hi_r, pm_lo_r};
                  pm_addr_r    <= pm_addr_r + PM_AW'(1'b1);
               end
               default: ;
            endcase
         end
      end
   end

   // IRQ bridge, core run bit and sticky FIFO error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_in_r   <= 32'h0000_0000;
         irq_pend_r <= 32'h0000_0000;
         irq_mask_r <= 32'h0000_0000;
         irq_out_r  <= 1'b0;
         ctrl_run_r <= 1'b0;
         h2c_ovf_r  <= 1'b0;
         c2h_udf_r  <= 1'b0;
         c2h_ovf_r  <= 1'b0;
         h2c_udf_r  <= 1'b0;
      end else begin
         irq_in_r   <= irq_in;
         irq_pend_r <= irq_pend_nxt_s;
         irq_mask_r <= irq_mask_nxt_s;
         irq_out_r  <= |(irq_pend_nxt_s & irq_mask_nxt_s);
         if (wb_wr_s && (wb.wb_adr == A_CTRL)) begin
            ctrl_run_r <= wb.wb_dat_w[0];
         end
         if (h2c_push_s && h2c_full_s) begin
            h2c_ovf_r <= 1'b1;
         end else if (wb_wr_s && (wb.wb_adr == A_STATUS) && wb.wb_dat_w[25]) begin
            h2c_ovf_r <= 1'b0;
         end
         if (c2h_pop_s && c2h_empty_s) begin
            c2h_udf_r <= 1'b1;
         end else if (wb_wr_s && (wb.wb_adr == A_STATUS) && wb.wb_dat_w[26]) begin
            c2h_udf_r <= 1'b0;
         end
         if (c2h_push_s && c2h_full_s) begin
            c2h_ovf_r <= 1'b1;
         end
         if (h2c_pop_s && h2c_empty_s) begin
            h2c_udf_r <= 1'b1;
         end
      end
   end

   // Shared GP registers; the core write is issued last so it wins a collision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_GP; i++) begin
            gp_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (wb_wr_s && wb_gp_hit_s) begin
            gp_r[wb.wb_adr[3:0]] <= wb.wb_dat_w;
         end
         if (praxos_port_wr && core_gp_hit_s) begin
            gp_r[praxos_port_addr[3:0]] <= praxos_port_wr_data;
         end
      end
   end

   assign wb.wb_ack          = ack_r & wb.wb_cyc;
   assign wb.wb_err          = err_r & wb.wb_cyc;
   assign wb.wb_dat_r        = dat_r_r;
   assign wb.wb_stall        = 1'b0;
   assign irq_out            = irq_out_r;
   assign praxos_rst_n       = ctrl_run_r;
   assign praxos_pm_wr       = pm_wr_r;
   assign praxos_pm_wr_addr  = pm_wr_addr_r;
   assign praxos_pm_wr_data  = pm_wr_data_r;
endmodule

// File: tb/tb_praxos_mbox_ctrl.sv
// Bench for praxos_mbox_ctrl: a queue/array model of the register map is
// advanced on every rising edge and compared against the DUT on every falling
// edge; directed steps also pin key results to hand-computed literals.
module tb_praxos_mbox_ctrl;
   localparam int NUM_GP = 16;
   localparam int PM_AW  = 8;
   localparam int PM_DW  = 36;
   localparam int DEPTH  = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic [31:0] irq_in;
   logic irq_out, praxos_rst_n, praxos_pm_wr;
   logic [PM_AW-1:0] praxos_pm_wr_addr;
   logic [PM_DW-1:0] praxos_pm_wr_data;
   logic [4:0] praxos_port_addr;
   logic praxos_port_rd, praxos_port_wr;
   logic [31:0] praxos_port_wr_data, praxos_port_rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   praxos_mbox_ctrl_if wb ();

   praxos_mbox_ctrl #(.NUM_GP(NUM_GP), .PM_AW(PM_AW), .PM_DW(PM_DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wb(wb), .irq_in(irq_in), .irq_out(irq_out),
      .praxos_rst_n(praxos_rst_n), .praxos_pm_wr_addr(praxos_pm_wr_addr),
      .praxos_pm_wr(praxos_pm_wr), .praxos_pm_wr_data(praxos_pm_wr_data),
      .praxos_port_addr(praxos_port_addr), .praxos_port_rd(praxos_port_rd),
      .praxos_port_wr(praxos_port_wr), .praxos_port_wr_data(praxos_port_wr_data),
      .praxos_port_rd_data(praxos_port_rd_data)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid = 1'b0;
   logic [31:0] m_pend, m_mask, m_irqq, m_lo;
   logic [3:0]  m_hi;
   logic [7:0]  m_paddr;
   logic        m_run;
   logic [31:0] m_h2c[$];
   logic [31:0] m_c2h[$];
   bit          m_h2c_ovf, m_c2h_udf, m_c2h_ovf, m_h2c_udf;
   logic [31:0] m_gp [NUM_GP];
   logic        e_ack, e_err, e_pm_wr, e_irq, e_run;
   logic [31:0] e_dat;
   logic [7:0]  e_pm_addr;
   logic [35:0] e_pm_data;
   int          m_hsz, m_csz;
   bit          m_flush;
   logic [31:0] m_d, m_pd;

   function automatic logic [31:0] m_status(input bit ovf, input bit udf);
      return 32'(m_h2c.size()) + (32'(m_c2h.size()) << 16) + (32'(ovf) << 25) + (32'(udf) << 26);
   endfunction

   function automatic logic [31:0] m_wb_read(input logic [4:0] a);
      if (a >= 5'd16) return m_gp[a - 5'd16];
      case (a)
         5'd0: return m_pend;
         5'd1: return m_irqq;
         5'd2: return m_lo;
         5'd3: return {28'h0, m_hi};
         5'd4: return {24'h0, m_paddr};
         5'd6: return {31'h0, m_run};
         5'd7: return m_mask;
         5'd8: return (m_c2h.size() != 0) ? m_c2h[0] : 32'h0;
         5'd9: return m_status(m_h2c_ovf, m_c2h_udf);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_port_read(input logic [4:0] a);
      if (a >= 5'd16) return m_gp[a - 5'd16];
      case (a)
         5'd1: return m_irqq;
         5'd2: return (m_h2c.size() != 0) ? m_h2c[0] : 32'h0;
         5'd3: return m_status(m_c2h_ovf, m_h2c_udf);
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model with the inputs present at this rising edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_pend = 0; m_mask = 0; m_irqq = 0; m_lo = 0; m_hi = 0; m_paddr = 0; m_run = 0;
         m_h2c.delete(); m_c2h.delete();
         m_h2c_ovf = 0; m_c2h_udf = 0; m_c2h_ovf = 0; m_h2c_udf = 0;
         for (int i = 0; i < NUM_GP; i++) m_gp[i] = 0;
         e_ack = 0; e_err = 0; e_dat = 0; e_pm_wr = 0; e_pm_addr = 0; e_pm_data = 0;
         e_irq = 0; e_run = 0;
         m_valid = 1'b1;
      end else begin
         m_hsz = m_h2c.size(); m_csz = m_c2h.size(); m_flush = 0;
         m_d = wb.wb_dat_w; m_pd = praxos_port_wr_data;
         e_ack = 0; e_err = 0; e_dat = 0; e_pm_wr = 0;
         if (wb.wb_cyc && wb.wb_stb) begin
            if (wb.wb_we) begin
               if (wb.wb_adr == 5'd8 && m_hsz == DEPTH) e_err = 1; else e_ack = 1;
               case (wb.wb_adr)
                  5'd0: m_pend = m_pend & ~m_d;
                  5'd2: m_lo = m_d;
                  5'd3: m_hi = m_d[3:0];
                  5'd4: m_paddr = m_d[7:0];
                  5'd5: begin
                     e_pm_wr = 1; e_pm_addr = m_paddr; e_pm_data = {m_hi, m_lo};
                     m_paddr = m_paddr + 8'd1;
                  end
                  5'd6: begin m_run = m_d[0]; m_flush = m_d[1]; end
                  5'd7: m_mask = m_d;
                  5'd8: if (m_hsz < DEPTH) m_h2c.push_back(m_d); else m_h2c_ovf = 1;
                  5'd9: begin
                     if (m_d[25]) m_h2c_ovf = 0;
                     if (m_d[26]) m_c2h_udf = 0;
                  end
                  default: if (wb.wb_adr >= 5'd16) m_gp[wb.wb_adr - 5'd16] = m_d;
               endcase
            end else begin
               e_dat = m_wb_read(wb.wb_adr);
               if (wb.wb_adr == 5'd8) begin
                  if (m_csz == 0) begin e_err = 1; m_c2h_udf = 1; end
                  else begin e_ack = 1; void'(m_c2h.pop_front()); end
               end else e_ack = 1;
            end
         end
         if (praxos_port_rd && praxos_port_addr == 5'd2) begin
            if (m_hsz == 0) m_h2c_udf = 1; else void'(m_h2c.pop_front());
         end
         if (praxos_port_wr) begin
            if (praxos_port_addr == 5'd0) m_pend = m_pend | m_pd;
            if (praxos_port_addr == 5'd2) begin
               if (m_csz < DEPTH) m_c2h.push_back(m_pd); else m_c2h_ovf = 1;
            end
            if (praxos_port_addr >= 5'd16) m_gp[praxos_port_addr - 5'd16] = m_pd;
         end
         if (m_flush) begin m_h2c.delete(); m_c2h.delete(); end
         m_irqq = irq_in;
         e_irq = |(m_pend & m_mask);
         e_run = m_run;
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("wb_ack", 64'(wb.wb_ack), 64'(e_ack));
         check("wb_err", 64'(wb.wb_err), 64'(e_err));
         if (e_ack || e_err) check("wb_dat_r", 64'(wb.wb_dat_r), 64'(e_dat));
         check("wb_stall", 64'(wb.wb_stall), 64'd0);
         check("pm_wr", 64'(praxos_pm_wr), 64'(e_pm_wr));
         if (e_pm_wr) begin
            check("pm_wr_addr", 64'(praxos_pm_wr_addr), 64'(e_pm_addr));
            check("pm_wr_data", 64'(praxos_pm_wr_data), 64'(e_pm_data));
         end
         check("irq_out", 64'(irq_out), 64'(e_irq));
         check("praxos_rst_n", 64'(praxos_rst_n), 64'(e_run));
         check("port_rd_data", 64'(praxos_port_rd_data), 64'(m_port_read(praxos_port_addr)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wb_op(input logic we, input logic [4:0] adr, input logic [31:0] d,
                        output logic ack, output logic err, output logic [31:0] rd);
      @(posedge clk); #1;
      wb.wb_stb = 1'b1; wb.wb_we = we; wb.wb_adr = adr; wb.wb_dat_w = d;
      @(posedge clk); #1;
      wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
      ack = wb.wb_ack; err = wb.wb_err; rd = wb.wb_dat_r;
   endtask

   task automatic wb_wr(input logic [4:0] adr, input logic [31:0] d);
      logic a, e; logic [31:0] r;
      wb_op(1'b1, adr, d, a, e, r);
      check("wr_ack", 64'({a, e}), 64'd2);
   endtask

   task automatic wb_rd_chk(input string name, input logic [4:0] adr, input logic [31:0] exp);
      logic a, e; logic [31:0] r;
      wb_op(1'b0, adr, 32'h0, a, e, r);
      check({name, "_ack"}, 64'({a, e}), 64'd2);
      check(name, 64'(r), 64'(exp));
   endtask

   task automatic core_wr(input logic [4:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      praxos_port_wr = 1'b1; praxos_port_addr = a; praxos_port_wr_data = d;
      @(posedge clk); #1;
      praxos_port_wr = 1'b0;
   endtask

   task automatic core_pop(output logic [31:0] d);
      @(posedge clk); #1;
      praxos_port_rd = 1'b1; praxos_port_addr = 5'd2;
      #1 d = praxos_port_rd_data;
      @(posedge clk); #1;
      praxos_port_rd = 1'b0;
   endtask

   task automatic core_peek(input string name, input logic [4:0] a, input logic [31:0] exp);
      @(posedge clk); #1;
      praxos_port_addr = a;
      #1 check(name, 64'(praxos_port_rd_data), 64'(exp));
   endtask

   task automatic same_cycle(input logic [4:0] wa, input logic [31:0] wd,
                             input logic [4:0] pa, input logic [31:0] pd);
      @(posedge clk); #1;
      wb.wb_stb = 1'b1; wb.wb_we = 1'b1; wb.wb_adr = wa; wb.wb_dat_w = wd;
      praxos_port_wr = 1'b1; praxos_port_addr = pa; praxos_port_wr_data = pd;
      @(posedge clk); #1;
      wb.wb_stb = 1'b0; wb.wb_we = 1'b0; praxos_port_wr = 1'b0;
      check("same_cycle_ack", 64'(wb.wb_ack), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a, e;
      logic [31:0] r;
      rst_n = 1'b0; irq_in = 32'h0;
      wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0; wb.wb_adr = 5'd0;
      wb.wb_dat_w = 32'h0; wb.wb_sel = 4'hF;
      praxos_port_addr = 5'd0; praxos_port_rd = 1'b0; praxos_port_wr = 1'b0;
      praxos_port_wr_data = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_praxos_rst_n", 64'(praxos_rst_n), 64'd0);
      check("rst_irq_out", 64'(irq_out), 64'd0);
      check("rst_ack", 64'(wb.wb_ack), 64'd0);
      wb.wb_cyc = 1'b1;

      // Reset values of the readable map (MBOX left for the underflow step).
      for (int i = 0; i < 10; i++) begin
         if (i != 8) wb_rd_chk("rst_read", 5'(i), 32'h0);
      end

      irq_in = 32'hCAFE_0001;
      wb_rd_chk("irq_in_rd", 5'd1, 32'hCAFE_0001);
      core_peek("port_irq_in", 5'd1, 32'hCAFE_0001);

      // Program-memory loader with address wrap.
      wb_wr(5'd4, 32'h0000_00FE);
      wb_wr(5'd2, 32'h1234_5678);
      wb_wr(5'd3, 32'hFFFF_FFFA);
      wb_rd_chk("pm_hi_trunc", 5'd3, 32'h0000_000A);
      wb_wr(5'd5, 32'h0);
      check("go1_pulse", 64'(praxos_pm_wr), 64'd1);
      check("go1_addr", 64'(praxos_pm_wr_addr), 64'h0FE);
      check("go1_data", 64'(praxos_pm_wr_data), 64'hA_1234_5678);
      wb_wr(5'd5, 32'h0);
      check("go2_addr", 64'(praxos_pm_wr_addr), 64'h0FF);
      wb_wr(5'd2, 32'h8765_4321);
      wb_wr(5'd5, 32'h0);
      check("go3_addr", 64'(praxos_pm_wr_addr), 64'h000);
      check("go3_data", 64'(praxos_pm_wr_data), 64'hA_8765_4321);
      wb_rd_chk("pm_addr_after", 5'd4, 32'h0000_0001);

      // H2C overflow: eight pushes accepted, ninth refused.
      for (int i = 0; i < 9; i++) begin
         wb_op(1'b1, 5'd8, 32'h100 + 32'(i), a, e, r);
         check("h2c_push_resp", 64'({a, e}), (i < 8) ? 64'd2 : 64'd1);
      end
      wb_rd_chk("status_h2c_full", 5'd9, 32'h0200_0008);
      for (int i = 0; i < 8; i++) begin
         core_pop(r);
         check("h2c_pop_data", 64'(r), 64'h100 + 64'(i));
      end
      core_pop(r);
      check("h2c_pop_empty", 64'(r), 64'd0);
      core_peek("core_status_udf", 5'd3, 32'h0400_0000);

      // C2H underflow from the host and W1C of both host flags.
      wb_op(1'b0, 5'd8, 32'h0, a, e, r);
      check("c2h_pop_empty_resp", 64'({a, e}), 64'd1);
      check("c2h_pop_empty_data", 64'(r), 64'd0);
      wb_rd_chk("status_flags", 5'd9, 32'h0600_0000);
      wb_wr(5'd9, 32'h0400_0000);
      wb_rd_chk("status_udf_clr", 5'd9, 32'h0200_0000);
      wb_wr(5'd9, 32'h0200_0000);
      wb_rd_chk("status_ovf_clr", 5'd9, 32'h0000_0000);

      // C2H traffic, then run + flush in one CTRL write.
      core_wr(5'd2, 32'h0000_0011);
      core_wr(5'd2, 32'h0000_0022);
      wb_wr(5'd8, 32'h0000_0033);
      wb_rd_chk("status_counts", 5'd9, 32'h0002_0001);
      wb_rd_chk("c2h_pop", 5'd8, 32'h0000_0011);
      wb_wr(5'd6, 32'h0000_0003);
      check("run_after_ctrl", 64'(praxos_rst_n), 64'd1);
      wb_rd_chk("status_flushed", 5'd9, 32'h0);
      wb_rd_chk("ctrl_read", 5'd6, 32'h0000_0001);

      // IRQ: mask raises irq_out; set beats a same-cycle clear.
      core_wr(5'd0, 32'h0000_0005);
      check("irq_masked_off", 64'(irq_out), 64'd0);
      wb_wr(5'd7, 32'h0000_0004);
      check("irq_unmasked", 64'(irq_out), 64'd1);
      same_cycle(5'd0, 32'h0000_0004, 5'd0, 32'h0000_0004);
      check("irq_set_wins", 64'(irq_out), 64'd1);
      wb_rd_chk("irq_pend_kept", 5'd0, 32'h0000_0005);
      wb_wr(5'd0, 32'h0000_0004);
      check("irq_cleared", 64'(irq_out), 64'd0);
      wb_rd_chk("irq_pend_left", 5'd0, 32'h0000_0001);

      // GP collision, cross-side visibility, and unmapped addresses.
      same_cycle(5'd19, 32'h0000_AAAA, 5'd19, 32'h0000_5555);
      wb_rd_chk("gp3_core_wins", 5'd19, 32'h0000_5555);
      core_peek("gp3_core_view", 5'd19, 32'h0000_5555);
      wb_wr(5'd31, 32'hDEAD_BEEF);
      core_peek("gp15_core_view", 5'd31, 32'hDEAD_BEEF);
      wb_wr(5'd0, 32'h0000_0001);
      wb_wr(5'd6, 32'h0000_0000);
      check("run_off", 64'(praxos_rst_n), 64'd0);
      wb_rd_chk("gp_kept_when_held", 5'd19, 32'h0000_5555);
      wb_wr(5'd12, 32'hFFFF_FFFF);
      wb_rd_chk("unmapped_12", 5'd12, 32'h0);
      wb_rd_chk("pm_go_reads_0", 5'd5, 32'h0);

      // Reset arriving with a strobe in flight drops the response.
      @(posedge clk); #1;
      wb.wb_stb = 1'b1; wb.wb_we = 1'b0; wb.wb_adr = 5'd19; rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_drops_ack", 64'({wb.wb_ack, wb.wb_err}), 64'd0);
      wb.wb_stb = 1'b0; rst_n = 1'b1;
      wb_rd_chk("gp_after_reset", 5'd19, 32'h0);

      repeat (2) @(posedge clk);
      #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
